// File: rtl/sum_loop_proc.sv
`default_nettype none
// ============================================================================
// sum_loop_proc : micro-sequenced datapath summing 0..limit through a small RF.
// Optional macro SUM_LOOP_STEP_OUT_EN adds an OUT state reporting each partial sum.
// Revision: 1.0
// ============================================================================
module sum_loop_proc #(
    parameter int DATA_W   = 8,
    parameter int RF_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] limit,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              overflow
);

    localparam int ADDR_W = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] C_R0 = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] C_R1 = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] C_R2 = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] C_R3 = ADDR_W'(3);
    localparam logic [DATA_W-1:0] C_ONE = DATA_W'(1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_INIT_I   = 4'd1,
        S_INIT_SUM = 4'd2,
        S_INIT_ONE = 4'd3,
        S_CMP      = 4'd4,
        S_ADD      = 4'd5,
        S_INC      = 4'd6,
`ifdef SUM_LOOP_STEP_OUT_EN
        S_OUT      = 4'd7,
`endif
        S_DONE     = 4'd8
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   bound_q;
    logic                wrap_q;
    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_valid_q;
    logic                overflow_q;
    logic [DATA_W-1:0]   rf_q [RF_DEPTH];

    logic [ADDR_W-1:0]   w_ra1;
    logic [ADDR_W-1:0]   w_ra2;
    logic [ADDR_W-1:0]   w_wa;
    logic                w_we;
    logic                w_wr_one;
    logic [DATA_W-1:0]   w_rd1;
    logic [DATA_W-1:0]   w_rd2;
    logic [DATA_W:0]     w_add;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_carry;

    // Per-state operand selection and write-back control for the shared adder
    always_comb begin
        w_ra1    = C_R0;
        w_ra2    = C_R0;
        w_wa     = C_R0;
        w_we     = 1'b0;
        w_wr_one = 1'b0;
        case (state_q)
            S_INIT_I:   begin w_wa = C_R1; w_we = 1'b1; end
            S_INIT_SUM: begin w_wa = C_R2; w_we = 1'b1; end
            S_INIT_ONE: begin w_wa = C_R3; w_we = 1'b1; w_wr_one = 1'b1; end
            S_CMP:      begin w_ra1 = C_R1; w_ra2 = C_R2; end
            S_ADD:      begin w_ra1 = C_R2; w_ra2 = C_R1; w_wa = C_R2; w_we = 1'b1; end
            S_INC:      begin w_ra1 = C_R1; w_ra2 = C_R3; w_wa = C_R1; w_we = 1'b1; end
`ifdef SUM_LOOP_STEP_OUT_EN
            S_OUT:      begin w_ra2 = C_R2; end
`endif
            default:    ;
        endcase
    end

    assign w_rd1   = (w_ra1 == C_R0) ? '0 : rf_q[w_ra1];
    assign w_rd2   = (w_ra2 == C_R0) ? '0 : rf_q[w_ra2];
    assign w_add   = {1'b0, w_rd1} + {1'b0, w_rd2};
    assign w_carry = w_add[DATA_W];
    assign w_wdata = w_wr_one ? C_ONE : w_add[DATA_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < RF_DEPTH; k++) rf_q[k] <= '0;
        end else if (w_we && (w_wa != C_R0)) begin
            rf_q[w_wa] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bound_q     <= '0;
            wrap_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        bound_q    <= limit;
                        overflow_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_INIT_I;
                    end
                end
                S_INIT_I:   state_q <= S_INIT_SUM;
                S_INIT_SUM: state_q <= S_INIT_ONE;
                S_INIT_ONE: state_q <= S_CMP;
                S_CMP: begin
                    // wrap_q stops the loop once i has rolled past the all-ones bound
                    if ((w_rd1 <= bound_q) && !wrap_q) begin
                        state_q <= S_ADD;
                    end else begin
                        out_data_q  <= w_rd2;
                        out_valid_q <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_ADD: begin
                    if (w_carry) overflow_q <= 1'b1;
                    state_q <= S_INC;
                end
                S_INC: begin
                    if (w_carry) wrap_q <= 1'b1;
`ifdef SUM_LOOP_STEP_OUT_EN
                    state_q <= S_OUT;
`else
                    state_q <= S_CMP;
`endif
                end
`ifdef SUM_LOOP_STEP_OUT_EN
                S_OUT: begin
                    out_data_q  <= w_rd2;
                    out_valid_q <= 1'b1;
                    state_q     <= S_CMP;
                end
`endif
                S_DONE: begin
                    wrap_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: doc/sum_loop_proc.md
SUM_LOOP_PROC -- requirements
Module: sum_loop_proc

Interface
REQ-001 Parameter DATA_W, default 8: datapath and register-file word width, min 4.
REQ-002 Parameter RF_DEPTH, default 8: register-file entries, min 4; ADDR_W = clog2(RF_DEPTH).
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to run one computation; sampled only in IDLE.
REQ-006 limit  input  DATA_W  inclusive loop bound L; captured on start acceptance.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse, high only in state DONE.
REQ-009 out_data  output  DATA_W  registered result or step value.
REQ-010 out_valid  output  1  one-cycle pulse; out_data is valid when high.
REQ-011 overflow  output  1  sticky; a sum addition carried out of DATA_W during the current or last run.

Function
REQ-012 Internal register file: RF_DEPTH x DATA_W, two combinational read ports, one synchronous write port, entry 0 reads constant 0. R1 holds i, R2 holds sum, R3 holds constant 1.
REQ-013 Single adder: sum = RF[ra1] + RF[ra2], modulo 2^DATA_W; carry-out is retained.
REQ-014 Write-back mux: selects the adder output, or the constant 1 when writing R3.
REQ-015 FSM states: IDLE, INIT_I, INIT_SUM, INIT_ONE, CMP, ADD, INC, OUT, DONE.
REQ-016 IDLE: start=1 -> INIT_I; latches limit into a bound register; clears overflow.
REQ-017 INIT_I: R1=0. INIT_SUM: R2=0. INIT_ONE: R3=1. Each advances unconditionally.
REQ-018 CMP: if R1 <= bound (unsigned) and the wrap flag is clear -> ADD; otherwise loads out_data=R2 and goes to DONE.
REQ-019 ADD: R2=R2+R1; a carry-out sets overflow -> INC.
REQ-020 INC: R1=R1+R3; a carry-out (i wrapped to 0) sets the wrap flag -> OUT, or -> CMP when OUT is compiled out.
REQ-021 OUT: loads out_data=R2 -> CMP.
REQ-022 DONE: done=1 -> IDLE; the wrap flag clears.
REQ-023 out_valid is asserted in the cycle following each out_data load, so it coincides with done in DONE.
REQ-024 Result equals the sum of i for i=0..L, modulo 2^DATA_W.
REQ-025 Latency from the start-accept edge to done: 4L+9 cycles with STEP_OUT_EN, 3L+8 without.
REQ-026 start while busy is ignored; limit changes while busy are ignored.
REQ-027 L=0: exactly one iteration, result 0.
REQ-028 L=2^DATA_W-1: the loop terminates through the wrap flag after i=L; no infinite loop.
REQ-029 start asserted in the DONE cycle is ignored; start is accepted on the next IDLE cycle.

Reset
REQ-030 On reset: state=IDLE, all RF entries=0, bound=0, wrap flag=0; busy=0, done=0, out_valid=0, out_data=0, overflow=0.
REQ-031 Reset asserted mid-run aborts immediately; no done or out_valid pulse follows.

Configuration
REQ-032 Macro SUM_LOOP_STEP_OUT_EN, defined: state OUT exists; out_data and out_valid report the running sum after every iteration, plus the final value in DONE.
REQ-033 Macro SUM_LOOP_STEP_OUT_EN, undefined: state OUT is removed; INC -> CMP; out_valid pulses only with done.

Verification
REQ-034 DATA_W=8, L=10, macro defined: 11 step pulses 0,1,3,...,55, then done with out_data=55 at cycle 49; overflow=0.
REQ-035 Same stimulus, macro undefined: single out_valid with done at cycle 38, out_data=55.
REQ-036 L=0: done with out_data=0 at cycle 9 (macro defined) or 8 (undefined).
REQ-037 L=255, DATA_W=8: terminates, out_data=0x80 (32640 mod 256), overflow=1.
REQ-038 start pulsed while busy, then reset asserted at cycle 20: no done pulse; all outputs 0; next start with L=3 gives out_data=6.
